agc_loop_ctrl: RTL and testbench
================================

// Module: agc_loop_ctrl
// PURPOSE
//  Parametrised second-generation AGC loop controller between the RSSI/peak comparator and the
//  programmable-gain amplifier. Runs detect/adjust/settle windows on a sample strobe, keeps the
//  gain register internally and updates it with coarse-then-fine steps and saturation.
//  Declares lock after N consecutive in-range windows. Aborts on preamble timeout or external done.
// PARAMETERS
//  CNT_W       4   window counter width; window = 2**CNT_W sample_vld strobes
//  PRE_W       8   preamble counter width
//  PRE_LIMIT   127 preamble sample count that forces timeout (< 2**PRE_W)
//  GAIN_W      5   gain code width
//  GAIN_INIT   16  gain loaded on start
//  GAIN_MIN    0   lower gain clamp
//  GAIN_MAX    31  upper gain clamp
//  STEP_COARSE 4   step used until the first direction reversal
//  STEP_FINE   1   step used after the first reversal
//  LOCK_CNT    3   consecutive in-range windows required for lock (>=1)
// PORTS
//  clk          in   1       clock
//  RESETn       in   1       asynchronous active-low reset
//  start        in   1       level; high = run loop, low = return to IDLE
//  sample_vld   in   1       one-cycle strobe per comparator sample
//  indicator    in   1       sample qualifier: 1 = signal above target (reduce gain)
//  in_range     in   1       sample qualifier: 1 = signal inside target window
//  done_ext     in   1       external abort (packet detected); sampled every cycle
//  gain         out  GAIN_W  current gain code
//  gain_upd     out  1       one-cycle pulse when gain changes
//  detect_mode  out  1       high in DETECT
//  adjust       out  1       high in the ADJUST cycle
//  up_dn        out  1       direction of the last adjustment: 1 = up, 0 = down
//  locked       out  1       sticky: loop locked
//  timeout      out  1       sticky: preamble limit reached before lock
//  saturated    out  1       sticky: a step was clamped at GAIN_MIN/GAIN_MAX
//  state_o      out  3       state encoding (debug)
// BEHAVIOUR
//  Reset: state=IDLE, gain=GAIN_INIT, up_dn=1, all other outputs and counters 0.
//  States: IDLE -> DETECT -> ADJUST -> SETTLE -> DETECT ... ; DONE is terminal until start falls.
//  IDLE: start=1 -> DETECT next cycle. On entry: gain<=GAIN_INIT; clear counters and sticky flags.
//  DETECT:
//   - Each sample_vld increments win_cnt, high_cnt (if indicator) and the AND of in_range.
//   - The window ends on the strobe with win_cnt == all-ones; evaluation includes that sample.
//   - All samples in range: lock_cnt++. If lock_cnt reaches LOCK_CNT: DONE, locked=1.
//     Otherwise the next window starts in DETECT.
//   - Any sample out of range: lock_cnt<=0 and go to ADJUST.
//  ADJUST (1 cycle):
//   - dir = (high_cnt > 2**(CNT_W-1)) ? down : up.
//   - step = STEP_COARSE until the first cycle whose dir differs from the previous dir; STEP_FINE after.
//   - gain computed in GAIN_W+1 bits and clamped to [GAIN_MIN, GAIN_MAX].
//   - A clamp sets saturated. gain_upd pulses only if the gain value changes.
//   - up_dn<=dir. Then go to SETTLE.
//  SETTLE: count 2**CNT_W sample_vld strobes (gain ignored), then DETECT with cleared window counters.
//  Preamble counter:
//   - Counts every sample_vld in DETECT/ADJUST/SETTLE and saturates.
//   - At PRE_LIMIT: DONE with timeout=1, unless lock is declared in the same cycle (lock wins).
//  done_ext=1 in any running state: DONE next cycle with no flag set. It takes priority over timeout.
//   Same-cycle adjust is suppressed.
//  DONE: gain frozen. start=0 in any state -> IDLE next cycle; gain held until restart.
//  Async reset mid-operation returns everything to the reset values immediately.
//  Latency: window-end strobe -> ADJUST state is 1 cycle; ADJUST -> new gain visible is 1 cycle.
// STRUCTURE
//  agc_pkg: state localparams (IDLE=0, DETECT=1, ADJUST=2, SETTLE=3, DONE=4) and the direction
//   constants UP/DN.
//  Sub-module agc_window_counter (CNT_W): win_cnt, high_cnt, in-range AND, window_end pulse.
//   Shared by DETECT and SETTLE.
//  Top level holds the FSM, preamble counter, lock counter, gain arithmetic and sticky flags.
// TESTING
//  1. Reset then start, 16 samples all in_range, repeated x3 -> locked=1 after the 48th strobe;
//     gain=16, gain_upd never pulses.
//  2. Indicator=1 on 12 of 16 samples, out of range -> ADJUST; gain 16->12, up_dn=0,
//     gain_upd pulses once, then 16-strobe SETTLE.
//  3. Down window, then up window (indicator=0) -> gains 12 then 13 (fine step after reversal).
//  4. GAIN_INIT=2, repeated down windows -> gain clamps at 0, saturated=1; a further down window
//     leaves gain=0 with no gain_upd.
//  5. Never in range -> timeout=1 on strobe 127, state DONE; done_ext asserted the same cycle
//     instead -> DONE with timeout=0.
//  6. RESETn low mid-SETTLE -> gain=16, state IDLE asynchronously; start low in DONE -> IDLE;
//     restart clears the flags.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared constants for the AGC loop controller: FSM state codes and
// adjustment direction values.
package agc_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DETECT = 3'd1;
  localparam logic [2:0] ADJUST = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  function automatic logic is_running(input logic [2:0] st);
    return (st == DETECT) || (st == ADJUST) || (st == SETTLE);
  endfunction

endpackage

// File: rtl/agc_window_counter.sv
// Counts 2**CNT_W sample strobes per window, accumulating the number of
// "above target" samples and the AND of the in-range qualifier.
module agc_window_counter #(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           RESETn,
  input  logic           clr,
  input  logic           en,
  input  logic           indicator,
  input  logic           in_range,
  output logic [CNT_W:0] high_nxt,
  output logic           all_nxt,
  output logic           window_end
);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W:0]   high_cnt;
  logic             all_in;

  // Next-values include the current sample so the window-end strobe is evaluated.
  assign high_nxt   = high_cnt + {{CNT_W{1'b0}}, indicator};
  assign all_nxt    = all_in & in_range;
  assign window_end = en && (win_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      win_cnt  <= '0;
      high_cnt <= '0;
      all_in   <= 1'b1;
    end else if (clr) begin
      win_cnt  <= '0;
      high_cnt <= '0;
      all_in   <= 1'b1;
    end else if (en) begin
      if (window_end) begin
        win_cnt  <= '0;
        high_cnt <= '0;
        all_in   <= 1'b1;
      end else begin
        win_cnt  <= win_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        high_cnt <= high_nxt;
        all_in   <= all_nxt;
      end
    end
  end

endmodule

// File: rtl/agc_loop_ctrl.sv
// AGC loop controller: detect/adjust/settle windows, coarse-then-fine gain
// stepping with clamping, lock detection and preamble timeout.
module agc_loop_ctrl import agc_pkg::*; #(
  parameter int CNT_W       = 4,
  parameter int PRE_W       = 8,
  parameter int PRE_LIMIT   = 127,
  parameter int GAIN_W      = 5,
  parameter int GAIN_INIT   = 16,
  parameter int GAIN_MIN    = 0,
  parameter int GAIN_MAX    = 31,
  parameter int STEP_COARSE = 4,
  parameter int STEP_FINE   = 1,
  parameter int LOCK_CNT    = 3
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              start,
  input  logic              sample_vld,
  input  logic              indicator,
  input  logic              in_range,
  input  logic              done_ext,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_upd,
  output logic              detect_mode,
  output logic              adjust,
  output logic              up_dn,
  output logic              locked,
  output logic              timeout,
  output logic              saturated,
  output logic [2:0]        state_o
);

  localparam int LK_W = $clog2(LOCK_CNT + 1);

  localparam logic [GAIN_W:0]   STEP_C   = (GAIN_W+1)'(STEP_COARSE);
  localparam logic [GAIN_W:0]   STEP_F   = (GAIN_W+1)'(STEP_FINE);
  localparam logic [GAIN_W:0]   MIN_C    = (GAIN_W+1)'(GAIN_MIN);
  localparam logic [GAIN_W:0]   MAX_C    = (GAIN_W+1)'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] INIT_C   = GAIN_W'(GAIN_INIT);
  localparam logic [CNT_W:0]    HALF_C   = (CNT_W+1)'(2**(CNT_W-1));
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRE_LIMIT - 1);
  localparam logic [LK_W-1:0]   LK_LAST  = LK_W'(LOCK_CNT - 1);

  logic [2:0]        state, state_nxt;
  logic [GAIN_W-1:0] gain_q;
  logic [PRE_W-1:0]  pre_cnt;
  logic [LK_W-1:0]   lock_cnt;
  logic              up_dn_q, dir_q, have_prev, fine_q;
  logic              locked_q, timeout_q, sat_q, upd_q;

  logic              running, counting, cnt_en, cnt_clr;
  logic [CNT_W:0]    high_nxt;
  logic              all_nxt, win_end;
  logic              pre_hit, det_lock, reversal;
  logic [GAIN_W:0]   step, g_ext, g_sum, g_dif;
  logic [GAIN_W-1:0] gain_new;
  logic              clamp;

  assign running  = is_running(state);
  assign counting = (state == DETECT) || (state == SETTLE);
  assign cnt_en   = sample_vld && counting;
  assign cnt_clr  = !counting;

  agc_window_counter #(.CNT_W(CNT_W)) u_win (
    .clk        (clk),
    .RESETn     (RESETn),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .indicator  (indicator),
    .in_range   (in_range),
    .high_nxt   (high_nxt),
    .all_nxt    (all_nxt),
    .window_end (win_end)
  );

  assign pre_hit  = running && sample_vld && (pre_cnt == PRE_LAST);
  assign det_lock = (state == DETECT) && win_end && all_nxt && (lock_cnt == LK_LAST);

  // The reversal cycle itself already uses the fine step.
  assign reversal = have_prev && (dir_q != up_dn_q);
  assign step     = (fine_q || reversal) ? STEP_F : STEP_C;
  assign g_ext    = {1'b0, gain_q};
  assign g_sum    = g_ext + step;
  assign g_dif    = g_ext - step;

  always_comb begin
    gain_new = gain_q;
    clamp    = 1'b0;
    if (dir_q == UP) begin
      if (g_sum > MAX_C) begin
        gain_new = MAX_C[GAIN_W-1:0];
        clamp    = 1'b1;
      end else begin
        gain_new = g_sum[GAIN_W-1:0];
      end
    end else begin
      if (g_ext < (MIN_C + step)) begin
        gain_new = MIN_C[GAIN_W-1:0];
        clamp    = 1'b1;
      end else begin
        gain_new = g_dif[GAIN_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (!start) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   state_nxt = DETECT;
        DETECT, ADJUST, SETTLE: begin
          if (done_ext || det_lock || pre_hit) begin
            state_nxt = DONE;
          end else if (state == DETECT) begin
            if (win_end && !all_nxt) state_nxt = ADJUST;
          end else if (state == ADJUST) begin
            state_nxt = SETTLE;
          end else if (win_end) begin
            state_nxt = DETECT;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      gain_q    <= INIT_C;
      pre_cnt   <= '0;
      lock_cnt  <= '0;
      up_dn_q   <= UP;
      dir_q     <= UP;
      have_prev <= 1'b0;
      fine_q    <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      sat_q     <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      upd_q <= 1'b0;
      if (state == IDLE && start) begin
        gain_q    <= INIT_C;
        pre_cnt   <= '0;
        lock_cnt  <= '0;
        have_prev <= 1'b0;
        fine_q    <= 1'b0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
        sat_q     <= 1'b0;
      end else if (running && start) begin
        if (sample_vld && (pre_cnt != {PRE_W{1'b1}})) pre_cnt <= pre_cnt + PRE_W'(1);
        // An external abort wins over everything, including a same-cycle adjust.
        if (!done_ext) begin
          if (det_lock)     locked_q  <= 1'b1;
          else if (pre_hit) timeout_q <= 1'b1;
          if (state == DETECT && win_end) begin
            if (all_nxt) begin
              lock_cnt <= lock_cnt + LK_W'(1);
            end else begin
              lock_cnt <= '0;
              dir_q    <= (high_nxt > HALF_C) ? DN : UP;
            end
          end
          if (state == ADJUST) begin
            gain_q    <= gain_new;
            upd_q     <= (gain_new != gain_q);
            up_dn_q   <= dir_q;
            have_prev <= 1'b1;
            if (clamp)    sat_q  <= 1'b1;
            if (reversal) fine_q <= 1'b1;
          end
        end
      end
    end
  end

  assign gain        = gain_q;
  assign gain_upd    = upd_q;
  assign detect_mode = (state == DETECT);
  assign adjust      = (state == ADJUST);
  assign up_dn       = up_dn_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
  assign saturated   = sat_q;
  assign state_o     = state;

endmodule

// File: tb/tb_agc_loop_ctrl.sv
// Directed bench for agc_loop_ctrl: two instances (GAIN_INIT 16 and 2) share
// one stimulus stream; checks lock, stepping, clamping, timeout, abort and reset.
module tb_agc_loop_ctrl;

  logic       clk = 1'b0;
  logic       RESETn, start, sample_vld, indicator, in_range, done_ext;
  logic [4:0] gain1, gain2;
  logic       upd1, upd2, det1, det2, adj1, adj2, ud1, ud2;
  logic       lck1, lck2, to1, to2, sat1, sat2;
  logic [2:0] st1, st2;

  int checks = 0;
  int errors = 0;
  int upd1_n = 0;
  int upd2_n = 0;
  int base2;

  always #5 clk = ~clk;

  agc_loop_ctrl u_dut1 (
    .clk(clk), .RESETn(RESETn), .start(start), .sample_vld(sample_vld),
    .indicator(indicator), .in_range(in_range), .done_ext(done_ext),
    .gain(gain1), .gain_upd(upd1), .detect_mode(det1), .adjust(adj1),
    .up_dn(ud1), .locked(lck1), .timeout(to1), .saturated(sat1), .state_o(st1)
  );

  agc_loop_ctrl #(.GAIN_INIT(2)) u_dut2 (
    .clk(clk), .RESETn(RESETn), .start(start), .sample_vld(sample_vld),
    .indicator(indicator), .in_range(in_range), .done_ext(done_ext),
    .gain(gain2), .gain_upd(upd2), .detect_mode(det2), .adjust(adj2),
    .up_dn(ud2), .locked(lck2), .timeout(to2), .saturated(sat2), .state_o(st2)
  );

  always @(negedge clk) begin
    if (upd1) upd1_n++;
    if (upd2) upd2_n++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic ind, input logic inr);
    sample_vld = 1'b1;
    indicator  = ind;
    in_range   = inr;
    tick();
    sample_vld = 1'b0;
    indicator  = 1'b0;
    in_range   = 1'b0;
  endtask

  // One out-of-range detect window with 'hi' above-target samples, then the ADJUST cycle.
  task automatic oor_window(input int hi);
    for (int i = 0; i < 16; i++) strobe(i < hi, 1'b0);
  endtask

  task automatic settle();
    for (int i = 0; i < 16; i++) strobe(1'b0, 1'b0);
  endtask

  task automatic restart();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETn = 1'b0; start = 1'b0; sample_vld = 1'b0;
    indicator = 1'b0; in_range = 1'b0; done_ext = 1'b0;
    #12;
    chk("rst_state", st1, 0);
    chk("rst_gain1", gain1, 16);
    chk("rst_gain2", gain2, 2);
    chk("rst_up_dn", ud1, 1);
    chk("rst_flags", {lck1, to1, sat1, upd1}, 0);
    tick();
    RESETn = 1'b1;
    start  = 1'b1;
    tick();
    chk("start_detect", st1, 1);
    chk("detect_mode", det1, 1);

    // Lock after three clean windows
    for (int i = 0; i < 47; i++) strobe(1'b0, 1'b1);
    chk("lock_47_locked", lck1, 0);
    chk("lock_47_state", st1, 1);
    strobe(1'b0, 1'b1);
    chk("lock_48_locked", lck1, 1);
    chk("lock_48_state", st1, 4);
    chk("lock_gain", gain1, 16);
    chk("lock_no_upd", upd1_n, 0);
    start = 1'b0;
    tick();
    chk("done_to_idle", st1, 0);
    start = 1'b1;
    tick();
    chk("restart_detect", st1, 1);
    chk("restart_locked_clr", lck1, 0);

    // Down window, then up windows with fine step after reversal
    oor_window(12);
    chk("adj_state", st1, 2);
    chk("adj_pulse", adj1, 1);
    chk("adj_gain_before", gain1, 16);
    tick();
    chk("dn_state_settle", st1, 3);
    chk("dn_gain1", gain1, 12);
    chk("dn_up_dn", ud1, 0);
    chk("dn_gain_upd", upd1, 1);
    chk("dn_sat1", sat1, 0);
    chk("dn_gain2_clamp", gain2, 0);
    chk("dn_sat2", sat2, 1);
    for (int i = 0; i < 15; i++) strobe(1'b0, 1'b0);
    chk("settle_15", st1, 3);
    strobe(1'b0, 1'b0);
    chk("settle_16", st1, 1);
    chk("dn_upd_once", upd1_n, 1);
    oor_window(0);
    tick();
    chk("up_gain1_fine", gain1, 13);
    chk("up_up_dn", ud1, 1);
    chk("up_gain2_fine", gain2, 1);
    settle();
    oor_window(3);
    tick();
    chk("up2_gain1_fine", gain1, 14);
    chk("up2_gain2", gain2, 2);
    settle();
    chk("upd1_total", upd1_n, 3);

    // Clamp at zero, then a down window that leaves gain unchanged
    restart();
    chk("restart_gain2", gain2, 2);
    chk("restart_sat_clr", sat2, 0);
    oor_window(16);
    tick();
    chk("clamp_gain2", gain2, 0);
    chk("clamp_sat2", sat2, 1);
    settle();
    base2 = upd2_n;
    oor_window(9);
    tick();
    chk("clamp2_gain2", gain2, 0);
    chk("clamp2_no_pulse", upd2, 0);
    chk("clamp2_gain1", gain1, 8);
    settle();
    chk("clamp2_no_upd", upd2_n, base2);

    // Preamble timeout on strobe 127 (64 strobes so far in this run)
    for (int i = 0; i < 62; i++) strobe(1'b0, 1'b0);
    chk("pre126_timeout", to1, 0);
    chk("pre126_not_done", int'(st1 == 3'd4), 0);
    strobe(1'b0, 1'b0);
    chk("pre127_timeout", to1, 1);
    chk("pre127_state", st1, 4);
    chk("pre127_locked", lck1, 0);
    strobe(1'b0, 1'b0);
    chk("timeout_sticky", to1, 1);
    chk("done_hold", st1, 4);

    // External abort coinciding with strobe 127
    restart();
    chk("restart_timeout_clr", to1, 0);
    for (int i = 0; i < 126; i++) strobe(1'b0, 1'b0);
    done_ext = 1'b1;
    strobe(1'b0, 1'b0);
    done_ext = 1'b0;
    chk("abort_state", st1, 4);
    chk("abort_timeout", to1, 0);
    chk("abort_locked", lck1, 0);

    // Asynchronous reset mid-SETTLE
    restart();
    oor_window(12);
    tick();
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0);
    chk("mid_settle_state", st1, 3);
    chk("mid_settle_gain", gain1, 12);
    #2;
    RESETn = 1'b0;
    #1;
    chk("arst_state", st1, 0);
    chk("arst_gain1", gain1, 16);
    chk("arst_up_dn", ud1, 1);
    chk("arst_gain2", gain2, 2);
    chk("arst_sat2", sat2, 0);
    tick();
    RESETn = 1'b1;
    tick();
    chk("post_arst_detect", st1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
